cnt_rewind: RTL and testbench

Iterative inverse of the SKINNY-128-384+ TK1 (counter) tweakey permutation PT. It accepts a 128-bit TK1 state that has been advanced s rounds forward and returns it rewound by s rounds, applying one inverse permutation per clock. It sits in the decryption / tag-verification path, where the key schedule is walked backwards from the last-round TK1 state. The transfer uses a valid/ready handshake on both sides.

---
 rtl/cnt_rewind.sv | 83 ++++++++
 tb/tb_cnt_rewind.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cnt_rewind.sv
// cnt_rewind: walks a SKINNY-128-384+ TK1 (counter) tweakey state backwards.
// A TK1 state that has been advanced s rounds forward is loaded and the inverse
// permutation Q is applied once per clock, s = nr mod 16 times, because PT has
// order 16. The result is held on ko until the consumer takes it.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   ki/nr valid
//   in_ready   block can accept (high only while idle)
//   ki[127:0]  TK1 state to rewind, byte 0 = ki[127:120]
//   nr[NRW-1:0] rounds to rewind, only nr[3:0] matters
//   out_valid  ko holds the final result
//   out_ready  consumer accepts ko
//   ko[127:0]  rewound TK1 state (registered)
module cnt_rewind #(
  parameter int NRW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   ki,
  input  logic [NRW-1:0] nr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   ko
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]   state;
  logic [127:0] st;
  logic [3:0]   rem;

  // Upper round-count bits are a whole number of PT periods and drop out.
  logic unused_nr_hi;
  assign unused_nr_hi = ^nr[NRW-1:4];

  // One inverse step: out byte i = in byte Q[i],
  // Q = 8,9,10,11,12,13,14,15,2,0,4,7,6,3,5,1.
  function automatic logic [127:0] q_step(input logic [127:0] s);
    logic [7:0] b [16];
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    return {b[8], b[9], b[10], b[11], b[12], b[13], b[14], b[15],
            b[2], b[0], b[4],  b[7],  b[6],  b[3],  b[5],  b[1]};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign ko        = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      st    <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= ki;
            rem   <= nr[3:0];
            // A zero step count skips RUN so rem is never decremented past 0.
            state <= (nr[3:0] == 4'd0) ? HOLD : RUN;
          end
        end
        RUN: begin
          st  <= q_step(st);
          rem <= rem - 4'd1;
          if (rem == 4'd1) state <= HOLD;
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_rewind.sv
module tb_cnt_rewind;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ki;
  logic [5:0]   nr;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ko;

  cnt_rewind #(.NRW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ki        (ki),
    .nr        (nr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ko        (ko)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [127:0] sb_ko  [$];
  int           sb_cyc [$];

  localparam logic [127:0] K0   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] K0_1 = 128'h08090A0B0C0D0E0F0200040706030501;
  localparam logic [127:0] K0_8 = 128'h05060302070001040D0E0B0A0F08090C;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Forward permutation PT: out byte i = in byte P[i].
  function automatic logic [127:0] pt(input logic [127:0] v);
    int p [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = v[127-8*p[i] -: 8];
    return r;
  endfunction

  // Monitor: on each rising out_valid, pop the expected result and its cycle.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb_ko.size() == 0) begin
          chk("unexpected_out", {127'd0, out_valid}, 128'd0);
        end else begin
          logic [127:0] e;
          int ec;
          e  = sb_ko.pop_front();
          ec = sb_cyc.pop_front();
          chk("ko", ko, e);
          chk("latency", 128'(cyc), 128'(ec));
        end
      end
      prev_ov = out_valid;
    end
  end

  // Issue one transaction; inputs change on the falling edge.
  task automatic send(input logic [127:0] k, input logic [5:0] n,
                      input logic [127:0] e, input bit push);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("send_timeout", 128'd0, 128'd1);
    ki       = k;
    nr       = n;
    in_valid = 1'b1;
    if (push) begin
      sb_ko.push_back(e);
      sb_cyc.push_back(cyc + 1 + int'(n[3:0]));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb_ko.size() != 0 || !in_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb_ko.size() != 0) chk("drain_timeout", 128'(sb_ko.size()), 128'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] kh, kr, kf;
    logic [5:0]   nn;
    int           w;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    ki        = '0;
    nr        = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ko", ko, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    rst_n = 1'b1;

    // Directed vectors.
    send(K0, 6'd1,  K0_1, 1'b1); drain();
    send(K0, 6'd16, K0,   1'b1); drain();
    send(K0, 6'd0,  K0,   1'b1); drain();
    send(K0, 6'd40, K0_8, 1'b1); drain();

    // Back-pressure with in_valid toggling during RUN and HOLD.
    out_ready = 1'b0;
    send(K0, 6'd40, K0_8, 1'b1);
    w = 0;
    while (!out_valid && w < 30) begin
      in_valid = ~in_valid;
      ki       = {$urandom, $urandom, $urandom, $urandom};
      nr       = 6'd3;
      @(negedge clk);
      w++;
    end
    chk("bp_reach_hold", {127'd0, out_valid}, 128'd1);
    kh = ko;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      ki       = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_ko_stable", ko, K0_8);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    chk("bp_ko_held", ko, kh);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {127'd0, in_ready}, 128'd1);
    chk("release_out_valid", {127'd0, out_valid}, 128'd0);

    // Reset in the middle of a 12-step rewind.
    send(K0, 6'd12, K0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ko", ko, 128'd0);
    chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
    chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(K0, 6'd1, K0_1, 1'b1); drain();

    // Round trip: advance with PT, rewind with the DUT.
    for (int it = 0; it < 1000; it++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      nn = 6'($urandom_range(0, 63));
      kf = kr;
      for (int j = 0; j < int'(nn[3:0]); j++) kf = pt(kf);
      send(kf, nn, kr, 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
